// File: rtl/stripe_arbiter_pkg.sv
// Shared definitions for the two-requester stripe arbiter.
// Holds the FSM state encoding and the default datapath width and burst length.
// Imported by stripe_arbiter and available to anything that talks to it.
package stripe_arbiter_pkg;

  localparam int DATA_W_DEF  = 32;
  localparam int BURST_DEF   = 4;
  localparam int BURST_CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SERVE0 = 2'd1,
    SERVE1 = 2'd2
  } state_e;

endpackage

// File: rtl/stripe_arbiter.sv
// Purpose : round-robin burst arbiter feeding one word per cycle to a two-lane byte striper.
// Latency : 1 cycle from consumption (grant & req & ready) to valid_out/data_out/lane_tag.
// Backpressure: ready=0 freezes all state; only a requester dropping req can end a grant then.
//
// Ports:
//   clk, reset          - single clock, asynchronous active-high reset
//   req_k / data_k      - requester k (k=0,1) presents a word
//   ready               - striping datapath accepts a word this cycle
//   grant_k             - requester k owns the datapath (Moore, decoded from state)
//   valid_out/data_out  - registered word to the striper
//   lane_tag            - striper lane for data_out, alternates per word from 0 after reset
//   cnt_0, cnt_1        - wrapping count of words consumed per requester
module stripe_arbiter
  import stripe_arbiter_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int BURST  = BURST_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_0,
  input  logic [DATA_W-1:0] data_0,
  input  logic              req_1,
  input  logic [DATA_W-1:0] data_1,
  input  logic              ready,
  output logic              grant_0,
  output logic              grant_1,
  output logic              valid_out,
  output logic [DATA_W-1:0] data_out,
  output logic              lane_tag,
  output logic [7:0]        cnt_0,
  output logic [7:0]        cnt_1
);

  state_e                 state_q, state_d;
  logic [BURST_CNT_W-1:0] burst_q, burst_d;
  logic                   rr_q, rr_d;        // requester preferred when both ask from IDLE
  logic                   lane_q, lane_d;
  logic                   valid_q, valid_d;
  logic [DATA_W-1:0]      data_q, data_d;
  logic                   lane_tag_q, lane_tag_d;
  logic [7:0]             cnt_0_q, cnt_0_d;
  logic [7:0]             cnt_1_q, cnt_1_d;

  logic serving;
  logic sel;        // owner index while serving
  logic own_req;
  logic other_req;
  logic at_limit;
  logic consume;
  logic end_grant;

  assign serving   = (state_q != IDLE);
  assign sel       = (state_q == SERVE1);
  assign own_req   = sel ? req_1 : req_0;
  assign other_req = sel ? req_0 : req_1;
  // A full burst is retired on the cycle after its last word; that cycle is
  // the grant hand-over and does not consume.
  assign at_limit  = (burst_q == BURST_CNT_W'(BURST));
  assign consume   = serving && own_req && ready && !at_limit;
  // A dropped request ends the grant even under backpressure.
  assign end_grant = serving && (!own_req || (ready && at_limit));

  always_comb begin
    state_d    = state_q;
    burst_d    = burst_q;
    rr_d       = rr_q;
    lane_d     = lane_q;
    valid_d    = 1'b0;
    data_d     = data_q;
    lane_tag_d = lane_tag_q;
    cnt_0_d    = cnt_0_q;
    cnt_1_d    = cnt_1_q;

    case (state_q)
      IDLE: begin
        if (ready) begin
          if (req_0 && req_1) state_d = rr_q ? SERVE1 : SERVE0;
          else if (req_0)     state_d = SERVE0;
          else if (req_1)     state_d = SERVE1;
        end
      end
      default: begin
        if (end_grant) begin
          burst_d = '0;
          rr_d    = ~sel;
          if (other_req)    state_d = sel ? SERVE0 : SERVE1;
          else if (own_req) state_d = state_q;
          else              state_d = IDLE;
        end else if (consume) begin
          burst_d = burst_q + 1'b1;
        end
      end
    endcase

    if (consume) begin
      valid_d    = 1'b1;
      data_d     = sel ? data_1 : data_0;
      lane_tag_d = lane_q;
      lane_d     = ~lane_q;
      if (sel) cnt_1_d = cnt_1_q + 8'd1;
      else     cnt_0_d = cnt_0_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      burst_q    <= '0;
      rr_q       <= 1'b0;
      lane_q     <= 1'b0;
      valid_q    <= 1'b0;
      data_q     <= '0;
      lane_tag_q <= 1'b0;
      cnt_0_q    <= '0;
      cnt_1_q    <= '0;
    end else begin
      state_q    <= state_d;
      burst_q    <= burst_d;
      rr_q       <= rr_d;
      lane_q     <= lane_d;
      valid_q    <= valid_d;
      data_q     <= data_d;
      lane_tag_q <= lane_tag_d;
      cnt_0_q    <= cnt_0_d;
      cnt_1_q    <= cnt_1_d;
    end
  end

  assign grant_0   = (state_q == SERVE0);
  assign grant_1   = (state_q == SERVE1);
  assign valid_out = valid_q;
  assign data_out  = data_q;
  assign lane_tag  = lane_tag_q;
  assign cnt_0     = cnt_0_q;
  assign cnt_1     = cnt_1_q;

endmodule

// File: tb/tb_stripe_arbiter.sv
module tb_stripe_arbiter;

  localparam int DW = 32;
  localparam int BL = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          req_0, req_1, ready;
  logic [DW-1:0] data_0, data_1;
  logic          grant_0, grant_1, valid_out, lane_tag;
  logic [DW-1:0] data_out;
  logic [7:0]    cnt_0, cnt_1;

  logic          b1_grant_0, b1_grant_1, b1_valid_out, b1_lane_tag;
  logic [DW-1:0] b1_data_out;
  logic [7:0]    b1_cnt_0, b1_cnt_1;

  stripe_arbiter #(.DATA_W(DW), .BURST(BL)) u_dut (
    .clk(clk), .reset(reset),
    .req_0(req_0), .data_0(data_0), .req_1(req_1), .data_1(data_1), .ready(ready),
    .grant_0(grant_0), .grant_1(grant_1), .valid_out(valid_out), .data_out(data_out),
    .lane_tag(lane_tag), .cnt_0(cnt_0), .cnt_1(cnt_1)
  );

  stripe_arbiter #(.DATA_W(DW), .BURST(1)) u_dut_b1 (
    .clk(clk), .reset(reset),
    .req_0(req_0), .data_0(data_0), .req_1(req_1), .data_1(data_1), .ready(ready),
    .grant_0(b1_grant_0), .grant_1(b1_grant_1), .valid_out(b1_valid_out), .data_out(b1_data_out),
    .lane_tag(b1_lane_tag), .cnt_0(b1_cnt_0), .cnt_1(b1_cnt_1)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // ---------------- reference model (BURST = BL) ----------------
  int            m_owner;   // -1 = nobody holds the datapath
  int            m_taken;   // words taken in the current grant
  int            m_pref;    // who wins a tie from idle
  int            m_lane;
  int            m_valid;
  int            m_tag;
  int            m_cnt[2];
  logic [DW-1:0] m_data;

  task automatic model_reset();
    m_owner = -1; m_taken = 0; m_pref = 0; m_lane = 0;
    m_valid = 0; m_tag = 0; m_cnt[0] = 0; m_cnt[1] = 0; m_data = '0;
  endtask

  task automatic model_step();
    int r[2];
    logic [DW-1:0] d[2];
    int k, o;
    bit full, took, done;
    r[0] = int'(req_0); r[1] = int'(req_1);
    d[0] = data_0;      d[1] = data_1;
    m_valid = 0;
    if (m_owner < 0) begin
      if (ready) begin
        if (r[0] != 0 && r[1] != 0) m_owner = m_pref;
        else if (r[0] != 0)         m_owner = 0;
        else if (r[1] != 0)         m_owner = 1;
      end
    end else begin
      k = m_owner; o = 1 - k;
      full = (m_taken == BL);
      took = (r[k] != 0) && ready && !full;
      done = (r[k] == 0) || (ready && full);
      if (took) begin
        m_valid = 1; m_data = d[k]; m_tag = m_lane; m_lane = 1 - m_lane;
        m_cnt[k] = (m_cnt[k] + 1) % 256;
        m_taken++;
      end
      if (done) begin
        m_taken = 0; m_pref = o;
        if (r[o] != 0)      m_owner = o;
        else if (r[k] != 0) m_owner = k;
        else                m_owner = -1;
      end
    end
  endtask

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, " grant_0"},   grant_0,   32'(m_owner == 0));
    check({tag, " grant_1"},   grant_1,   32'(m_owner == 1));
    check({tag, " valid_out"}, valid_out, 32'(m_valid));
    check({tag, " data_out"},  data_out,  m_data);
    check({tag, " lane_tag"},  lane_tag,  32'(m_tag));
    check({tag, " cnt_0"},     cnt_0,     32'(m_cnt[0]));
    check({tag, " cnt_1"},     cnt_1,     32'(m_cnt[1]));
  endtask

  task automatic apply(input logic r0, input logic [DW-1:0] d0,
                       input logic r1, input logic [DW-1:0] d1, input logic rdy);
    req_0 = r0; data_0 = d0; req_1 = r1; data_1 = d1; ready = rdy;
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1; req_0 = 0; req_1 = 0; ready = 0; data_0 = '0; data_1 = '0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " grant_0"},   grant_0,   0);
    check({tag, " grant_1"},   grant_1,   0);
    check({tag, " valid_out"}, valid_out, 0);
    check({tag, " data_out"},  data_out,  0);
    check({tag, " lane_tag"},  lane_tag,  0);
    check({tag, " cnt_0"},     cnt_0,     0);
    check({tag, " cnt_1"},     cnt_1,     0);
  endtask

  // ---------------- single-requester burst table ----------------
  typedef struct {
    logic          r0;
    logic [DW-1:0] d0;
    logic          rdy;
    logic          g0;
    logic          v;
    logic [DW-1:0] dout;
    logic          tag;
    logic [7:0]    c0;
  } vec_t;

  vec_t tbl[9];
  int   exp_ord[9] = '{0, 0, 0, 0, 1, 1, 1, 1, 0};

  initial begin : watchdog
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : main
    bit owners[$];
    bit b1_owners[$];
    int words, cyc;

    // reset state, checked while reset is still asserted
    reset = 1'b1; req_0 = 0; req_1 = 0; ready = 0; data_0 = '0; data_1 = '0;
    #3;
    check_all_zero("reset");
    check("reset b1 grant",  {b1_grant_0, b1_grant_1, b1_valid_out, b1_lane_tag}, 0);
    check("reset b1 data",   b1_data_out, 0);
    check("reset b1 counts", {b1_cnt_0, b1_cnt_1}, 0);
    @(negedge clk);
    reset = 1'b0;
    model_reset();

    // only requester 0, six words: gap after word 4, lanes alternate, cnt_0 = 6
    tbl[0] = '{1'b1, 32'hA000_0000, 1'b1, 1'b1, 1'b0, 32'h0,         1'b0, 8'd0};
    tbl[1] = '{1'b1, 32'hA000_0000, 1'b1, 1'b1, 1'b1, 32'hA000_0000, 1'b0, 8'd1};
    tbl[2] = '{1'b1, 32'hA000_0001, 1'b1, 1'b1, 1'b1, 32'hA000_0001, 1'b1, 8'd2};
    tbl[3] = '{1'b1, 32'hA000_0002, 1'b1, 1'b1, 1'b1, 32'hA000_0002, 1'b0, 8'd3};
    tbl[4] = '{1'b1, 32'hA000_0003, 1'b1, 1'b1, 1'b1, 32'hA000_0003, 1'b1, 8'd4};
    tbl[5] = '{1'b1, 32'hA000_0004, 1'b1, 1'b1, 1'b0, 32'hA000_0003, 1'b1, 8'd4};
    tbl[6] = '{1'b1, 32'hA000_0004, 1'b1, 1'b1, 1'b1, 32'hA000_0004, 1'b0, 8'd5};
    tbl[7] = '{1'b1, 32'hA000_0005, 1'b1, 1'b1, 1'b1, 32'hA000_0005, 1'b1, 8'd6};
    tbl[8] = '{1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 32'hA000_0005, 1'b1, 8'd6};
    for (int i = 0; i < 9; i++) begin
      apply(tbl[i].r0, tbl[i].d0, 1'b0, '0, tbl[i].rdy);
      check($sformatf("tbl%0d grant_0", i),   grant_0,   tbl[i].g0);
      check($sformatf("tbl%0d grant_1", i),   grant_1,   0);
      check($sformatf("tbl%0d valid_out", i), valid_out, tbl[i].v);
      check($sformatf("tbl%0d data_out", i),  data_out,  tbl[i].dout);
      check($sformatf("tbl%0d lane_tag", i),  lane_tag,  tbl[i].tag);
      check($sformatf("tbl%0d cnt_0", i),     cnt_0,     tbl[i].c0);
    end

    // both requesting: 4-word bursts alternate; BURST=1 alternates per word
    do_reset();
    for (int c = 0; c < 14; c++) begin
      apply(1'b1, 32'h0000_0100 + c, 1'b1, 32'h1000_0100 + c, 1'b1);
      if (valid_out) begin
        owners.push_back(data_out[28]);
        if (owners.size() == 8) begin
          check("rr cnt_0 after 8", cnt_0, 4);
          check("rr cnt_1 after 8", cnt_1, 4);
        end
      end
      if (b1_valid_out) b1_owners.push_back(b1_data_out[28]);
    end
    check("rr word count >= 9", 32'(owners.size() >= 9), 1);
    for (int i = 0; i < 9 && i < owners.size(); i++)
      check($sformatf("rr order word %0d", i), owners[i], exp_ord[i]);
    check("b1 word count >= 6", 32'(b1_owners.size() >= 6), 1);
    for (int i = 0; i < 6 && i < b1_owners.size(); i++)
      check($sformatf("b1 order word %0d", i), b1_owners[i], i % 2);

    // ready low for 3 cycles mid-burst
    do_reset();
    apply(1'b1, 32'h30, 1'b0, '0, 1'b1);
    apply(1'b1, 32'h30, 1'b0, '0, 1'b1);
    apply(1'b1, 32'h31, 1'b0, '0, 1'b1);
    for (int c = 0; c < 3; c++) begin
      apply(1'b1, 32'h32, 1'b0, '0, 1'b0);
      check($sformatf("stall%0d valid_out", c), valid_out, 0);
      check($sformatf("stall%0d grant_0", c),   grant_0,   1);
      check($sformatf("stall%0d lane_tag", c),  lane_tag,  1);
      check($sformatf("stall%0d cnt_0", c),     cnt_0,     2);
    end
    apply(1'b1, 32'h32, 1'b0, '0, 1'b1);
    check("resume data_out", data_out, 32'h32);
    check("resume lane_tag", lane_tag, 0);
    check("resume valid_out", valid_out, 1);
    apply(1'b1, 32'h33, 1'b0, '0, 1'b1);
    check("resume word4 valid", valid_out, 1);
    apply(1'b1, 32'h34, 1'b0, '0, 1'b1);
    check("resume burst end gap", valid_out, 0);

    // requester 0 drops after 2 words while requester 1 waits
    do_reset();
    apply(1'b1, 32'h40, 1'b1, 32'h50, 1'b1);
    apply(1'b1, 32'h40, 1'b1, 32'h50, 1'b1);
    apply(1'b1, 32'h41, 1'b1, 32'h50, 1'b1);
    apply(1'b0, '0,     1'b1, 32'h50, 1'b1);
    check("drop grant_1", grant_1, 1);
    check("drop grant_0", grant_0, 0);
    check("drop valid_out", valid_out, 0);
    for (int c = 0; c < 4; c++) begin
      apply(1'b0, '0, 1'b1, 32'h50 + c, 1'b1);
      check($sformatf("drop w%0d data", c),  data_out,  32'h50 + c);
      check($sformatf("drop w%0d valid", c), valid_out, 1);
    end
    apply(1'b0, '0, 1'b1, 32'h54, 1'b1);
    check("drop full burst gap", valid_out, 0);

    // reset pulsed during word 3
    do_reset();
    apply(1'b1, 32'h60, 1'b0, '0, 1'b1);
    apply(1'b1, 32'h60, 1'b0, '0, 1'b1);
    apply(1'b1, 32'h61, 1'b0, '0, 1'b1);
    data_0 = 32'h62;
    #2 reset = 1'b1;
    #1;
    check_all_zero("midreset");
    @(posedge clk);
    @(negedge clk);
    check_all_zero("midreset held");
    reset = 1'b0;
    model_reset();
    apply(1'b1, 32'h70, 1'b0, '0, 1'b1);
    check("post reset grant_0", grant_0, 1);
    apply(1'b1, 32'h70, 1'b0, '0, 1'b1);
    check("post reset data", data_out, 32'h70);
    check("post reset lane_tag", lane_tag, 0);

    // 256 words from requester 1 wrap cnt_1
    do_reset();
    words = 0; cyc = 0;
    while (words < 256 && cyc < 600) begin
      apply(1'b0, '0, 1'b1, 32'(words), 1'b1);
      cyc++;
      if (valid_out) begin
        words++;
        if (words == 255) check("cnt_1 at 255", cnt_1, 255);
      end
    end
    check("wrap words seen", words, 256);
    check("cnt_1 wrapped", cnt_1, 0);
    check("cnt_0 untouched", cnt_0, 0);

    // randomized traffic against the reference model
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      apply(logic'($urandom_range(0, 9) < 7), $urandom,
            logic'($urandom_range(0, 9) < 6), $urandom,
            logic'($urandom_range(0, 3) != 0));
      check_model($sformatf("rnd%0d", c));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
